datapath: RTL and testbench

Single-bus 32-bit RISC datapath holding PC, IR, MAR, MDR, Y, the 64-bit Z result pair (ZHI/ZLO) and general registers R0 and R5, around a combinational ALU. An external control unit or testbench drives one-hot bus-source selects, register load enables and a 5-bit ALU opcode each cycle. Memory is modelled by `m_data_in` feeding the MDR input mux.

---
 rtl/datapath_pkg.sv | 20 ++
 rtl/datapath_if.sv | 50 +++++
 rtl/datapath_alu.sv | 49 ++++
 rtl/datapath.sv | 96 +++++++++
 tb/tb_datapath.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// Shared constants for the single-bus datapath: default word width and ALU opcodes.
package datapath_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

endpackage

// File: rtl/datapath_if.sv
// Control/observation bundle between the control unit (master) and the datapath (slave).
interface datapath_if
  import datapath_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
);

  // bus-source selects
  logic             pc_out;
  logic             zlo_out;
  logic             zhi_out;
  logic             mdr_out;
  logic             r0_out;
  logic             r5_out;
  // register load enables
  logic             mar_enable;
  logic             mdr_enable;
  logic             ir_enable;
  logic             y_enable;
  logic             z_enable;
  logic             pc_enable;
  logic             r0_enable;
  logic             r5_enable;
  logic             pc_increment;
  logic             read;
  logic [4:0]       op_code;
  logic [WIDTH-1:0] m_data_in;
  // observation / address
  logic [WIDTH-1:0] bus_data;
  logic [WIDTH-1:0] mar_addr;
  // IR contents, feeding the control unit's instruction decoder
  logic [WIDTH-1:0] ir_data;

  modport master (
    output pc_out, zlo_out, zhi_out, mdr_out, r0_out, r5_out,
    output mar_enable, mdr_enable, ir_enable, y_enable, z_enable,
    output pc_enable, r0_enable, r5_enable, pc_increment, read,
    output op_code, m_data_in,
    input  bus_data, mar_addr, ir_data
  );

  modport slave (
    input  pc_out, zlo_out, zhi_out, mdr_out, r0_out, r5_out,
    input  mar_enable, mdr_enable, ir_enable, y_enable, z_enable,
    input  pc_enable, r0_enable, r5_enable, pc_increment, read,
    input  op_code, m_data_in,
    output bus_data, mar_addr, ir_data
  );

endinterface

// File: rtl/datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus; 2*WIDTH result split into ZHI/ZLO.
module alu
  import datapath_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [4:0]         op_code,
  output logic [2*WIDTH-1:0] result
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;

  assign shamt = b[SHW-1:0];

  // opcode decode; single-word results leave the upper half zero
  always_comb begin
    result = '0;
    case (op_code)
      OP_ADD:  result[WIDTH-1:0] = a + b;
      OP_SUB:  result[WIDTH-1:0] = a - b;
      OP_AND:  result[WIDTH-1:0] = a & b;
      OP_OR:   result[WIDTH-1:0] = a | b;
      // a shift by WIDTH yields 0, so a zero rotate amount falls out naturally
      OP_ROR:  result[WIDTH-1:0] = (a >> shamt) | (a << (WIDTH - int'(shamt)));
      OP_ROL:  result[WIDTH-1:0] = (a << shamt) | (a >> (WIDTH - int'(shamt)));
      OP_SHR:  result[WIDTH-1:0] = a >> shamt;
      OP_SHRA: result[WIDTH-1:0] = $signed(a) >>> shamt;
      OP_SHL:  result[WIDTH-1:0] = a << shamt;
      OP_DIV: begin
        // divide by zero returns quotient 0 and remainder = dividend
        if (b == '0) begin
          result[2*WIDTH-1:WIDTH] = a;
        end else begin
          result[WIDTH-1:0]       = $signed(a) / $signed(b);
          result[2*WIDTH-1:WIDTH] = $signed(a) % $signed(b);
        end
      end
      OP_MUL:  result = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
      OP_NEG:  result[WIDTH-1:0] = '0 - b;
      OP_NOT:  result[WIDTH-1:0] = ~b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/datapath.sv
// Single-bus datapath: register file around one shared bus and the combinational ALU.
module datapath
  import datapath_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input logic       clk,
  input logic       clr,
  datapath_if.slave dp
);

  logic [WIDTH-1:0]   bus;
  logic [2*WIDTH-1:0] alu_result;

  logic [WIDTH-1:0] pc_q,  pc_d;
  logic [WIDTH-1:0] ir_q,  ir_d;
  logic [WIDTH-1:0] mar_q, mar_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic [WIDTH-1:0] y_q,   y_d;
  logic [WIDTH-1:0] zhi_q, zhi_d;
  logic [WIDTH-1:0] zlo_q, zlo_d;
  logic [WIDTH-1:0] r0_q,  r0_d;
  logic [WIDTH-1:0] r5_q,  r5_d;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a       (y_q),
    .b       (bus),
    .op_code (dp.op_code),
    .result  (alu_result)
  );

  // bus source mux, fixed priority, idle bus is zero
  always_comb begin
    bus = '0;
    if (dp.mdr_out)      bus = mdr_q;
    else if (dp.pc_out)  bus = pc_q;
    else if (dp.zlo_out) bus = zlo_q;
    else if (dp.zhi_out) bus = zhi_q;
    else if (dp.r0_out)  bus = r0_q;
    else if (dp.r5_out)  bus = r5_q;
  end

  // next-state for every register; hold unless enabled
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    y_d   = y_q;
    zhi_d = zhi_q;
    zlo_d = zlo_q;
    r0_d  = r0_q;
    r5_d  = r5_q;

    if (dp.pc_enable)         pc_d = bus;
    else if (dp.pc_increment) pc_d = pc_q + WIDTH'(1);

    if (dp.ir_enable)  ir_d  = bus;
    if (dp.mar_enable) mar_d = bus;
    if (dp.mdr_enable) mdr_d = dp.read ? dp.m_data_in : bus;
    if (dp.y_enable)   y_d   = bus;
    if (dp.z_enable)   {zhi_d, zlo_d} = alu_result;
    if (dp.r0_enable)  r0_d  = bus;
    if (dp.r5_enable)  r5_d  = bus;
  end

  // register bank, cleared asynchronously by clr
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      zhi_q <= '0;
      zlo_q <= '0;
      r0_q  <= '0;
      r5_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      zhi_q <= zhi_d;
      zlo_q <= zlo_d;
      r0_q  <= r0_d;
      r5_q  <= r5_d;
    end
  end

  assign dp.bus_data = bus;
  assign dp.mar_addr = mar_q;
  assign dp.ir_data  = ir_q;

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed scenarios plus randomized control words against a behavioural model.
module tb_datapath;

  localparam bit [4:0] T_ADD  = 5'd3;
  localparam bit [4:0] T_SUB  = 5'd4;
  localparam bit [4:0] T_AND  = 5'd5;
  localparam bit [4:0] T_OR   = 5'd6;
  localparam bit [4:0] T_ROR  = 5'd7;
  localparam bit [4:0] T_ROL  = 5'd8;
  localparam bit [4:0] T_SHR  = 5'd9;
  localparam bit [4:0] T_SHRA = 5'd10;
  localparam bit [4:0] T_SHL  = 5'd11;
  localparam bit [4:0] T_DIV  = 5'd15;
  localparam bit [4:0] T_MUL  = 5'd16;
  localparam bit [4:0] T_NEG  = 5'd17;
  localparam bit [4:0] T_NOT  = 5'd18;

  localparam int S_PC = 0, S_ZLO = 1, S_ZHI = 2, S_MDR = 3, S_R0 = 4, S_R5 = 5;

  typedef struct packed {
    bit        pc_out, zlo_out, zhi_out, mdr_out, r0_out, r5_out;
    bit        mar_en, mdr_en, ir_en, y_en, z_en, pc_en, r0_en, r5_en, pc_inc, rd;
    bit [4:0]  op;
    bit [31:0] mem;
  } ctrl_t;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  bit [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_zhi, m_zlo, m_r0, m_r5;

  datapath_if #(.WIDTH(32)) dp_if ();

  datapath #(.WIDTH(32)) dut (
    .clk (clk),
    .clr (clr),
    .dp  (dp_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic apply(input ctrl_t c);
    dp_if.pc_out       = c.pc_out;
    dp_if.zlo_out      = c.zlo_out;
    dp_if.zhi_out      = c.zhi_out;
    dp_if.mdr_out      = c.mdr_out;
    dp_if.r0_out       = c.r0_out;
    dp_if.r5_out       = c.r5_out;
    dp_if.mar_enable   = c.mar_en;
    dp_if.mdr_enable   = c.mdr_en;
    dp_if.ir_enable    = c.ir_en;
    dp_if.y_enable     = c.y_en;
    dp_if.z_enable     = c.z_en;
    dp_if.pc_enable    = c.pc_en;
    dp_if.r0_enable    = c.r0_en;
    dp_if.r5_enable    = c.r5_en;
    dp_if.pc_increment = c.pc_inc;
    dp_if.read         = c.rd;
    dp_if.op_code      = c.op;
    dp_if.m_data_in    = c.mem;
  endtask

  task automatic model_zero();
    {m_pc, m_ir, m_mar, m_mdr, m_y, m_zhi, m_zlo, m_r0, m_r5} = '0;
  endtask

  function automatic bit [31:0] ref_bus(input ctrl_t c);
    if (c.mdr_out) return m_mdr;
    if (c.pc_out)  return m_pc;
    if (c.zlo_out) return m_zlo;
    if (c.zhi_out) return m_zhi;
    if (c.r0_out)  return m_r0;
    if (c.r5_out)  return m_r5;
    return 32'h0;
  endfunction

  function automatic bit [63:0] alu_ref(input bit [4:0] op, input bit [31:0] a, input bit [31:0] b);
    int        s;
    bit [31:0] r;
    longint    sa, sb, q, m, p;
    s  = int'(b & 32'd31);
    r  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      T_ADD:  return {32'h0, a + b};
      T_SUB:  return {32'h0, a - b};
      T_AND:  return {32'h0, a & b};
      T_OR:   return {32'h0, a | b};
      T_ROR:  begin for (int i = 0; i < 32; i++) r[i] = a[(i + s) % 32]; return {32'h0, r}; end
      T_ROL:  begin for (int i = 0; i < 32; i++) r[(i + s) % 32] = a[i]; return {32'h0, r}; end
      T_SHR:  begin for (int i = 0; i < 32; i++) r[i] = (i + s < 32) ? a[i + s] : 1'b0; return {32'h0, r}; end
      T_SHRA: begin for (int i = 0; i < 32; i++) r[i] = (i + s < 32) ? a[i + s] : a[31]; return {32'h0, r}; end
      T_SHL:  begin for (int i = 0; i < 32; i++) r[i] = (i >= s) ? a[i - s] : 1'b0; return {32'h0, r}; end
      T_DIV: begin
        if (b == 0) return {a, 32'h0};
        q = sa / sb;
        m = sa % sb;
        return {m[31:0], q[31:0]};
      end
      T_MUL: begin p = sa * sb; return p; end
      T_NEG:  return {32'h0, 32'h0 - b};
      T_NOT:  return {32'h0, ~b};
      default: return 64'h0;
    endcase
  endfunction

  // one clocked step: check the bus before the edge, then advance the model
  task automatic cycle(input ctrl_t c);
    bit [31:0] b;
    bit [63:0] z;
    apply(c);
    #1;
    b = ref_bus(c);
    z = alu_ref(c.op, m_y, b);
    check_val("bus", dp_if.bus_data, b);
    @(posedge clk);
    #1;
    if (c.mar_en) m_mar = b;
    if (c.ir_en)  m_ir  = b;
    if (c.y_en)   m_y   = b;
    if (c.r0_en)  m_r0  = b;
    if (c.r5_en)  m_r5  = b;
    if (c.mdr_en) m_mdr = c.rd ? c.mem : b;
    if (c.z_en)   {m_zhi, m_zlo} = z;
    if (c.pc_en)       m_pc = b;
    else if (c.pc_inc) m_pc = m_pc + 32'd1;
    apply('0);
    check_val("mar", dp_if.mar_addr, m_mar);
    check_val("ir", dp_if.ir_data, m_ir);
  endtask

  task automatic peek(input string tag, input int src, input bit [31:0] exp);
    ctrl_t c;
    c = '0;
    case (src)
      S_PC:    c.pc_out  = 1'b1;
      S_ZLO:   c.zlo_out = 1'b1;
      S_ZHI:   c.zhi_out = 1'b1;
      S_MDR:   c.mdr_out = 1'b1;
      S_R0:    c.r0_out  = 1'b1;
      default: c.r5_out  = 1'b1;
    endcase
    apply(c);
    #1;
    check_val(tag, dp_if.bus_data, exp);
    apply('0);
  endtask

  task automatic peek_all();
    peek("pc", S_PC, m_pc);
    peek("zlo", S_ZLO, m_zlo);
    peek("zhi", S_ZHI, m_zhi);
    peek("mdr", S_MDR, m_mdr);
    peek("r0", S_R0, m_r0);
    peek("r5", S_R5, m_r5);
  endtask

  task automatic mem_to_mdr(input bit [31:0] v);
    ctrl_t c;
    c = '0; c.rd = 1'b1; c.mdr_en = 1'b1; c.mem = v;
    cycle(c);
  endtask

  initial begin
    ctrl_t     c;
    bit [4:0]  ops [13];
    bit [31:0] b;

    ops = '{T_ADD, T_SUB, T_AND, T_OR, T_ROR, T_ROL, T_SHR, T_SHRA, T_SHL, T_DIV, T_MUL, T_NEG, T_NOT};
    apply('0);
    model_zero();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_bus", dp_if.bus_data, 32'h0);
    check_val("rst_mar", dp_if.mar_addr, 32'h0);
    peek_all();
    @(negedge clk);
    clr = 1'b1;

    // register loads through MDR
    mem_to_mdr(32'h22);
    c = '0; c.mdr_out = 1'b1; c.r5_en = 1'b1; cycle(c);
    peek("r5_load", S_R5, 32'h0000_0022);
    mem_to_mdr(32'h24);
    c = '0; c.mdr_out = 1'b1; c.r0_en = 1'b1; cycle(c);
    peek("r0_load", S_R0, 32'h0000_0024);

    // NOT
    c = '0; c.r0_out = 1'b1; c.op = T_NOT; c.z_en = 1'b1; cycle(c);
    peek("not_zlo", S_ZLO, 32'hFFFF_FFDB);
    peek("not_zhi", S_ZHI, 32'h0);
    c = '0; c.zlo_out = 1'b1; c.r5_en = 1'b1; cycle(c);
    peek("not_r5", S_R5, 32'hFFFF_FFDB);

    // fetch
    c = '0; c.pc_out = 1'b1; c.mar_en = 1'b1; c.pc_inc = 1'b1; cycle(c);
    check_val("fetch_mar", dp_if.mar_addr, 32'h0);
    peek("fetch_pc", S_PC, 32'h1);
    mem_to_mdr(32'h9280_0000);
    c = '0; c.mdr_out = 1'b1; c.ir_en = 1'b1; cycle(c);
    check_val("fetch_ir", dp_if.ir_data, 32'h9280_0000);

    // add / sub with Y=0x22, bus=R0=0x24
    mem_to_mdr(32'h22);
    c = '0; c.mdr_out = 1'b1; c.y_en = 1'b1; cycle(c);
    c = '0; c.r0_out = 1'b1; c.op = T_ADD; c.z_en = 1'b1; cycle(c);
    peek("add_zlo", S_ZLO, 32'h46);
    c.op = T_SUB; cycle(c);
    peek("sub_zlo", S_ZLO, 32'hFFFF_FFFE);
    peek("sub_zhi", S_ZHI, 32'h0);

    // mul
    mem_to_mdr(32'hFFFF_FFFE);
    c = '0; c.mdr_out = 1'b1; c.y_en = 1'b1; cycle(c);
    mem_to_mdr(32'h3);
    c = '0; c.mdr_out = 1'b1; c.op = T_MUL; c.z_en = 1'b1; cycle(c);
    peek("mul_zhi", S_ZHI, 32'hFFFF_FFFF);
    peek("mul_zlo", S_ZLO, 32'hFFFF_FFFA);

    // div and div by zero
    c = '0; c.r0_out = 1'b1; c.y_en = 1'b1; cycle(c);
    mem_to_mdr(32'h5);
    c = '0; c.mdr_out = 1'b1; c.op = T_DIV; c.z_en = 1'b1; cycle(c);
    peek("div_zlo", S_ZLO, 32'h7);
    peek("div_zhi", S_ZHI, 32'h1);
    mem_to_mdr(32'h0);
    c = '0; c.mdr_out = 1'b1; c.op = T_DIV; c.z_en = 1'b1; cycle(c);
    peek("div0_zlo", S_ZLO, 32'h0);
    peek("div0_zhi", S_ZHI, 32'h24);

    // undefined opcode clears Z
    c = '0; c.r0_out = 1'b1; c.op = T_MUL; c.z_en = 1'b1; cycle(c);
    c = '0; c.r0_out = 1'b1; c.op = 5'd0; c.z_en = 1'b1; cycle(c);
    peek("badop_zlo", S_ZLO, 32'h0);
    peek("badop_zhi", S_ZHI, 32'h0);

    // bus priority: MDR beats PC
    mem_to_mdr(32'h1234);
    c = '0; c.mdr_out = 1'b1; c.pc_out = 1'b1; c.r0_out = 1'b1;
    apply(c);
    #1;
    check_val("bus_prio", dp_if.bus_data, 32'h1234);
    apply('0);

    // pc_enable wins over pc_increment; PC wraps
    c = '0; c.mdr_out = 1'b1; c.pc_en = 1'b1; c.pc_inc = 1'b1; cycle(c);
    peek("pc_en_wins", S_PC, 32'h1234);
    mem_to_mdr(32'hFFFF_FFFF);
    c = '0; c.mdr_out = 1'b1; c.pc_en = 1'b1; cycle(c);
    c = '0; c.pc_inc = 1'b1; cycle(c);
    peek("pc_wrap", S_PC, 32'h0);

    // same register drives and loads: old value on the bus
    c = '0; c.pc_out = 1'b1; c.pc_inc = 1'b1; cycle(c);
    c = '0; c.pc_out = 1'b1; c.pc_inc = 1'b1;
    apply(c);
    #1;
    check_val("pc_self_bus", dp_if.bus_data, 32'h1);
    @(posedge clk);
    #1;
    apply('0);
    m_pc = 32'h2;
    peek("pc_self_after", S_PC, 32'h2);

    // reset mid-operation
    mem_to_mdr(32'h22);
    c = '0; c.mdr_out = 1'b1; c.r5_en = 1'b1; c.y_en = 1'b1; cycle(c);
    c = '0; c.r5_out = 1'b1; c.op = T_ADD; c.z_en = 1'b1; cycle(c);
    @(negedge clk);
    clr = 1'b0;
    model_zero();
    #1;
    peek("clr_r5", S_R5, 32'h0);
    peek("clr_pc", S_PC, 32'h0);
    peek("clr_zlo", S_ZLO, 32'h0);
    peek("clr_zhi", S_ZHI, 32'h0);
    check_val("clr_mar", dp_if.mar_addr, 32'h0);
    c = '0; c.rd = 1'b1; c.mdr_en = 1'b1; c.mem = 32'hAB; c.pc_inc = 1'b1;
    apply(c);
    @(posedge clk);
    #1;
    apply('0);
    peek("clr_mdr_hold", S_MDR, 32'h0);
    peek("clr_pc_hold", S_PC, 32'h0);
    @(negedge clk);
    clr = 1'b1;
    c = '0; c.pc_inc = 1'b1; cycle(c);
    peek("resume_pc", S_PC, 32'h1);

    // randomized control words
    for (int n = 0; n < 400; n++) begin
      c = '0;
      c.pc_out  = ($urandom_range(0, 4) == 0);
      c.zlo_out = ($urandom_range(0, 4) == 0);
      c.zhi_out = ($urandom_range(0, 4) == 0);
      c.mdr_out = ($urandom_range(0, 4) == 0);
      c.r0_out  = ($urandom_range(0, 4) == 0);
      c.r5_out  = ($urandom_range(0, 4) == 0);
      c.mar_en  = ($urandom_range(0, 2) == 0);
      c.mdr_en  = ($urandom_range(0, 2) == 0);
      c.ir_en   = ($urandom_range(0, 2) == 0);
      c.y_en    = ($urandom_range(0, 2) == 0);
      c.z_en    = ($urandom_range(0, 1) == 0);
      c.pc_en   = ($urandom_range(0, 3) == 0);
      c.r0_en   = ($urandom_range(0, 2) == 0);
      c.r5_en   = ($urandom_range(0, 2) == 0);
      c.pc_inc  = ($urandom_range(0, 1) == 0);
      c.rd      = ($urandom_range(0, 1) == 0);
      c.mem     = ($urandom_range(0, 3) == 0) ? 32'(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 40))
                                              : $urandom;
      c.op      = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31)) : ops[$urandom_range(0, 12)];
      b = ref_bus(c);
      if (c.op == T_DIV && m_y == 32'h8000_0000 && b == 32'hFFFF_FFFF) c.op = T_ADD;
      cycle(c);
      if (n % 8 == 7) peek_all();
    end
    peek_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
